// File: rtl/cc_reg_load_arbiter_if.sv
// Request/response bundle between the game-logic requesters and the shared-register arbiter.
interface cc_reg_load_arbiter_if #(
   parameter int DATA_WIDTH = 4,
   parameter int NUM_REQ    = 4
);
   logic [NUM_REQ-1:0]    CC_REGARB_req_InBUS;
   logic [DATA_WIDTH-1:0] CC_REGARB_data0_InBUS;
   logic [DATA_WIDTH-1:0] CC_REGARB_data1_InBUS;
   logic [DATA_WIDTH-1:0] CC_REGARB_data2_InBUS;
   logic [DATA_WIDTH-1:0] CC_REGARB_data3_InBUS;
   logic                  CC_REGARB_clear_InHigh;
   logic [NUM_REQ-1:0]    CC_REGARB_grant_OutBUS;
   logic                  CC_REGARB_load_OutHigh;
   logic [DATA_WIDTH-1:0] CC_REGARB_data_OutBUS;
   logic                  CC_REGARB_regClear_OutHigh;

   modport master (
      output CC_REGARB_req_InBUS, CC_REGARB_data0_InBUS, CC_REGARB_data1_InBUS,
             CC_REGARB_data2_InBUS, CC_REGARB_data3_InBUS, CC_REGARB_clear_InHigh,
      input  CC_REGARB_grant_OutBUS, CC_REGARB_load_OutHigh, CC_REGARB_data_OutBUS,
             CC_REGARB_regClear_OutHigh
   );

   modport slave (
      input  CC_REGARB_req_InBUS, CC_REGARB_data0_InBUS, CC_REGARB_data1_InBUS,
             CC_REGARB_data2_InBUS, CC_REGARB_data3_InBUS, CC_REGARB_clear_InHigh,
      output CC_REGARB_grant_OutBUS, CC_REGARB_load_OutHigh, CC_REGARB_data_OutBUS,
             CC_REGARB_regClear_OutHigh
   );
endinterface

// File: rtl/cc_reg_load_arbiter.sv
// Round-robin arbiter for the write port of one shared CC_REG data register.
// Clear outranks all requests; every output is registered.
module cc_reg_load_arbiter #(
   parameter int DATA_WIDTH = 4,
   parameter int NUM_REQ    = 4
) (
   input logic                  CC_REGARB_CLOCK_50,
   input logic                  CC_REGARB_RESET_InHigh,
   cc_reg_load_arbiter_if.slave bus
);
   typedef enum logic [1:0] {INIT, IDLE, GRANT, CLEAR} state_t;

   state_t                state, stateNext;
   logic [1:0]            ptr, ptrNext;
   logic [NUM_REQ-1:0]    grantNext;
   logic                  loadNext, regClearNext;
   logic [DATA_WIDTH-1:0] dataNext;
   logic [DATA_WIDTH-1:0] dataIn [NUM_REQ];
   logic                  found;
   logic [1:0]            winIdx, idx;

   assign dataIn[0] = bus.CC_REGARB_data0_InBUS;
   assign dataIn[1] = bus.CC_REGARB_data1_InBUS;
   assign dataIn[2] = bus.CC_REGARB_data2_InBUS;
   assign dataIn[3] = bus.CC_REGARB_data3_InBUS;

   // First requester at or above the pointer, wrapping 3->0.
   always_comb begin
      found  = 1'b0;
      winIdx = '0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ptr + 2'(k);
         if (!found && bus.CC_REGARB_req_InBUS[idx]) begin
            found  = 1'b1;
            winIdx = idx;
         end
      end
   end

   always_comb begin
      stateNext    = state;
      ptrNext      = ptr;
      grantNext    = '0;
      loadNext     = 1'b0;
      regClearNext = 1'b0;
      dataNext     = bus.CC_REGARB_data_OutBUS;
      if (state == INIT) begin
         // Register was held clear during INIT; requests are left for next cycle.
         stateNext = IDLE;
      end else if (bus.CC_REGARB_clear_InHigh) begin
         stateNext    = CLEAR;
         regClearNext = 1'b1;
         dataNext     = '0;
      end else if (found) begin
         stateNext         = GRANT;
         grantNext[winIdx] = 1'b1;
         loadNext          = 1'b1;
         dataNext          = dataIn[winIdx];
         ptrNext           = winIdx + 2'd1;
      end else begin
         stateNext = IDLE;
      end
   end

   always_ff @(posedge CC_REGARB_CLOCK_50) begin
      if (CC_REGARB_RESET_InHigh) begin
         state                          <= INIT;
         ptr                            <= '0;
         bus.CC_REGARB_grant_OutBUS     <= '0;
         bus.CC_REGARB_load_OutHigh     <= 1'b0;
         bus.CC_REGARB_data_OutBUS      <= '0;
         bus.CC_REGARB_regClear_OutHigh <= 1'b1;
      end else begin
         state                          <= stateNext;
         ptr                            <= ptrNext;
         bus.CC_REGARB_grant_OutBUS     <= grantNext;
         bus.CC_REGARB_load_OutHigh     <= loadNext;
         bus.CC_REGARB_data_OutBUS      <= dataNext;
         bus.CC_REGARB_regClear_OutHigh <= regClearNext;
      end
   end
endmodule
